apb_irq_slave: RTL and testbench

- APB3 responder holding the interrupt controller register file.
- Captures 4 single-cycle interrupt trigger pulses into pending bits, masks them with an enable register, and raises a registered IRQ with a fixed-priority source ID.
- Sits between the APB interconnect and the CPU interrupt line.
- This is the completer end of the APB write/read sequences our bench masters issue: address 3 = enable, address 2 = clear.

---
 rtl/apb_irq_slave.sv | 152 +++++++++++++++
 tb/tb_apb_irq_slave.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/apb_irq_slave.sv
// APB3 completer for a small interrupt controller: pending/enable registers and a registered
// fixed-priority IRQ output. Define APB_IRQ_WAIT_STATE_EN to insert one wait state per transfer.
module apb_irq_slave #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [NUM_IRQ-1:0] irq_trigger,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o
);

  // Handshake: a transfer starts when psel & !penable is seen (SETUP cycle) and completes on
  // the edge where the slave is in ST_ACCESS with psel & penable (pready is 1 in that state).
  // Dropping psel before completion returns to idle with no register update.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_ACTIVE = 2'd1;
  localparam logic [1:0] A_CLEAR  = 2'd2;
  localparam logic [1:0] A_ENABLE = 2'd3;

  state_e             state_q, state_d;
  logic [1:0]         addr_q, addr_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic [31:0]        prdata_q, prdata_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;

  logic               setup;
  logic               dec_err;
  logic               commit;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] active_src;
  logic [31:0]        rd_val;
  logic               pwdata_unused;

  assign pwdata_unused = ^pwdata[31:NUM_IRQ];

  assign setup   = psel & ~penable;
  assign dec_err = (paddr[31:2] != 30'd0) |
                   (pwrite & ((paddr[1:0] == A_STATUS) | (paddr[1:0] == A_ACTIVE)));
  assign commit  = (state_q == ST_ACCESS) & psel & penable & wr_q & ~err_q;
  assign active_src = pending_q & enable_q;

  always_comb begin
    rd_val = 32'd0;
    case (paddr[1:0])
      A_STATUS: rd_val = 32'(pending_q);
      A_ACTIVE: begin
        rd_val[8]        = irq_q;
        rd_val[ID_W-1:0] = irq_id_q;
      end
      A_ENABLE: rd_val = 32'(enable_q);
      default:  rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    case (state_q)
      ST_IDLE:   if (!setup) state_d = ST_IDLE;
      ST_WAIT:   state_d = psel ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // A SETUP cycle seen from idle, or directly after a completed ACCESS, starts a new transfer.
    if (setup && (state_q == ST_IDLE || state_q == ST_ACCESS)) begin
`ifdef APB_IRQ_WAIT_STATE_EN
      state_d = ST_WAIT;
`else
      state_d = ST_ACCESS;
`endif
      addr_d = paddr[1:0];
      wr_d   = pwrite;
      err_d  = dec_err;
      if (!pwrite) prdata_d = dec_err ? 32'd0 : rd_val;
    end
  end

  always_comb begin
    clr_mask = '0;
    enable_d = enable_q;
    if (commit && addr_q == A_CLEAR)  clr_mask = pwdata[NUM_IRQ-1:0];
    if (commit && addr_q == A_ENABLE) enable_d = pwdata[NUM_IRQ-1:0];
    // A trigger on the same edge as its clear wins.
    pending_d = (pending_q & ~clr_mask) | irq_trigger;
  end

  always_comb begin
    irq_d    = |active_src;
    irq_id_d = irq_id_q;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active_src[i]) irq_id_d = ID_W'(i);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 2'd0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= 32'd0;
      pending_q <= '0;
      enable_q  <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

`ifdef APB_IRQ_WAIT_STATE_EN
  assign pready = (state_q == ST_ACCESS);
`else
  assign pready = 1'b1;
`endif
  assign pslverr  = err_q & (state_q == ST_ACCESS);
  assign prdata   = prdata_q;
  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_apb_irq_slave.sv
// Directed bench for apb_irq_slave: APB register access, pending/clear races, priority,
// decode errors and reset during a transfer.
module tb_apb_irq_slave;
  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;
`ifdef APB_IRQ_WAIT_STATE_EN
  localparam int    EXP_WAITS  = 1;
  localparam logic  EXP_RST_RDY = 1'b0;
`else
  localparam int    EXP_WAITS  = 0;
  localparam logic  EXP_RST_RDY = 1'b1;
`endif

  logic               pclk, rst_n;
  logic               psel, penable, pwrite;
  logic [31:0]        paddr, pwdata, prdata;
  logic               pready, pslverr;
  logic [NUM_IRQ-1:0] irq_trigger;
  logic               irq_o;
  logic [ID_W-1:0]    irq_id_o;

  int n_vec = 0;
  int n_err = 0;

  apb_irq_slave #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
    .pclk(pclk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq_trigger(irq_trigger), .irq_o(irq_o), .irq_id_o(irq_id_o)
  );

  // clock / reset
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver: one APB transfer; trig is driven during the completing cycle
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [NUM_IRQ-1:0] trig,
                          output logic [31:0] rdata, output logic err, output int waits);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 8) begin
      @(negedge pclk);
      waits++;
    end
    if (!pready) check_vec("pready_timeout", 32'(pready), 32'd1);
    rdata = prdata;
    err   = pslverr;
    irq_trigger = trig;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; irq_trigger = '0;
  endtask

  task automatic apb_wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input logic [NUM_IRQ-1:0] trig);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(1'b1, addr, data, trig, rd, err, w);
    check_vec({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic apb_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(1'b0, addr, 32'd0, '0, rd, err, w);
    check_vec({tag, "_data"}, rd, exp_data);
    check_vec({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic pulse(input logic [NUM_IRQ-1:0] trig);
    @(negedge pclk);
    irq_trigger = trig;
    @(negedge pclk);
    irq_trigger = '0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_trigger = '0;
    repeat (3) @(negedge pclk);
    check_vec("rst_prdata", prdata, 32'd0);
    check_vec("rst_pslverr", 32'(pslverr), 32'd0);
    check_vec("rst_irq", 32'(irq_o), 32'd0);
    check_vec("rst_id", 32'(irq_id_o), 32'd0);
    check_vec("rst_pready", 32'(pready), 32'(EXP_RST_RDY));
    rst_n = 1'b1;

    // enable bit 0 only; bit 1 pends without raising irq
    apb_xfer(1'b1, 32'd3, 32'h1, '0, rd, err, w);
    check_vec("en1_err", 32'(err), 32'd0);
    check_vec("en1_waits", 32'(w), 32'(EXP_WAITS));
    pulse(4'b0010);
    apb_rd("status_2", 32'd0, 32'h2, 1'b0);
    check_vec("irq_masked", 32'(irq_o), 32'd0);

    // bit 0: pending after edge k, irq after edge k+1
    pulse(4'b0001);
    check_vec("irq_lat_k", 32'(irq_o), 32'd0);
    @(negedge pclk);
    check_vec("irq_lat_k1", 32'(irq_o), 32'd1);
    check_vec("id_lat_k1", 32'(irq_id_o), 32'd0);
    apb_rd("active_100", 32'd1, 32'h100, 1'b0);

    // priority and clear
    apb_wr("en_f", 32'd3, 32'hF, 1'b0, '0);
    apb_wr("clr1", 32'd2, 32'h1, 1'b0, '0);
    check_vec("clr1_id_hold", 32'(irq_id_o), 32'd0);
    @(negedge pclk);
    check_vec("clr1_id", 32'(irq_id_o), 32'd1);
    check_vec("clr1_irq", 32'(irq_o), 32'd1);
    apb_wr("clr2", 32'd2, 32'h2, 1'b0, '0);
    @(negedge pclk);
    check_vec("clr2_irq", 32'(irq_o), 32'd0);
    check_vec("clr2_id_hold", 32'(irq_id_o), 32'd1);
    apb_rd("status_0", 32'd0, 32'h0, 1'b0);

    // set wins over clear on the same edge
    apb_wr("clr4_race", 32'd2, 32'h4, 1'b0, 4'b0100);
    apb_rd("status_race", 32'd0, 32'h4, 1'b0);
    apb_rd("active_102", 32'd1, 32'h102, 1'b0);

    // decode errors
    apb_wr("wr_a0", 32'd0, 32'hF, 1'b1, '0);
    apb_rd("status_after_err", 32'd0, 32'h4, 1'b0);
    apb_wr("wr_a1", 32'd1, 32'hF, 1'b1, '0);
    apb_rd("rd_a7", 32'd7, 32'h0, 1'b1);
    apb_rd("rd_hi", 32'h1000_0003, 32'h0, 1'b1);
    apb_wr("wr_hi_en", 32'h0010_0003, 32'h0, 1'b1, '0);
    apb_rd("en_kept", 32'd3, 32'hF, 1'b0);
    apb_rd("rd_clear", 32'd2, 32'h0, 1'b0);

    // disable and clear bit 2
    apb_wr("en_0", 32'd3, 32'h0, 1'b0, '0);
    apb_wr("clr4", 32'd2, 32'h4, 1'b0, '0);
    apb_rd("status_clr4", 32'd0, 32'h0, 1'b0);
    check_vec("irq_off", 32'(irq_o), 32'd0);

    // reset during a transfer (WAIT cycle in the wait build)
    apb_wr("en_5", 32'd3, 32'h5, 1'b0, '0);
    pulse(4'b0100);
    @(negedge pclk);
    check_vec("pre_rst_irq", 32'(irq_o), 32'd1);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd3; pwdata = 32'hF;
    @(negedge pclk);
    penable = 1'b1;
    check_vec("mid_pready", 32'(pready), 32'(EXP_WAITS == 0));
    rst_n = 1'b0;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    check_vec("mid_rst_irq", 32'(irq_o), 32'd0);
    check_vec("mid_rst_pready", 32'(pready), 32'(EXP_RST_RDY));
    rst_n = 1'b1;
    apb_rd("mid_rst_en", 32'd3, 32'h0, 1'b0);
    apb_rd("mid_rst_status", 32'd0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
